// File: rtl/line_code_pkg.sv
// Shared types and constants for the HDBn / AMI line encoder.
// Tags travel through the delay line; symbols are the ternary codes on o_code.
package line_code_pkg;

  typedef enum logic [1:0] {
    TAG_ZERO = 2'd0,
    TAG_MARK = 2'd1,
    TAG_B    = 2'd2,
    TAG_V    = 2'd3
  } tag_t;

  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_POS  = 2'b01;
  localparam logic [1:0] SYM_NEG  = 2'b10;

  localparam logic MODE_AMI = 1'b0;
  localparam logic MODE_HDB = 1'b1;

endpackage

// File: rtl/lc_polarity.sv
// Registered output stage: turns an emitted tag into a ternary symbol and
// tracks the polarity of the last nonzero symbol on the line.
module lc_polarity
  import line_code_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       emit,
  input  tag_t       tag,
  output logic       valid,
  output logic [1:0] code,
  output logic       bpulse,
  output logic       viol
);

  logic last_neg;
  logic next_neg;
  logic [1:0] next_code;
  logic nonzero;

  // MARK and B alternate against the last pulse; V deliberately repeats it.
  always_comb begin
    next_neg  = last_neg;
    next_code = SYM_ZERO;
    nonzero   = 1'b0;
    case (tag)
      TAG_MARK, TAG_B: begin
        next_neg  = ~last_neg;
        nonzero   = 1'b1;
        next_code = next_neg ? SYM_NEG : SYM_POS;
      end
      TAG_V: begin
        next_neg  = last_neg;
        nonzero   = 1'b1;
        next_code = next_neg ? SYM_NEG : SYM_POS;
      end
      default: begin
        next_neg  = last_neg;
        next_code = SYM_ZERO;
        nonzero   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      code     <= SYM_ZERO;
      bpulse   <= 1'b0;
      viol     <= 1'b0;
      last_neg <= 1'b1;
    end else begin
      valid  <= emit;
      bpulse <= emit && (tag == TAG_B);
      viol   <= emit && (tag == TAG_V);
      if (emit) begin
        code <= next_code;
        if (nonzero) begin
          last_neg <= next_neg;
        end
      end
    end
  end

endmodule

// File: rtl/hdbn_encoder.sv
// HDBn / AMI line encoder: a D-deep tag delay line with zero-run substitution,
// followed by the registered polarity stage.
module hdbn_encoder
  import line_code_pkg::*;
#(
  parameter int N_HDB = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_data,
  input  logic       i_mode,
  output logic       o_valid,
  output logic [1:0] o_code,
  output logic       o_bpulse,
  output logic       o_viol
);

  localparam int D  = N_HDB + 1;
  localparam int CW = $clog2(D + 1);
  localparam logic [CW-1:0] D_CNT = CW'(D);
  localparam logic [CW-1:0] ONE   = CW'(1);

  tag_t          line      [D];
  tag_t          line_next [D];
  logic [CW-1:0] fill;
  logic [CW-1:0] fill_next;
  logic [CW-1:0] run;
  logic [CW-1:0] run_next;
  logic [CW-1:0] run_inc;
  logic          parity;
  logic          parity_next;
  logic          prev_mode;
  logic          prev_mode_next;
  logic          emit;

  // Everything advances only on an accepted bit; idle cycles leave state alone.
  always_comb begin
    line_next      = line;
    fill_next      = fill;
    run_next       = run;
    run_inc        = run;
    parity_next    = parity;
    prev_mode_next = prev_mode;
    emit           = 1'b0;
    if (i_valid) begin
      emit           = (fill == D_CNT);
      prev_mode_next = i_mode;
      if (fill != D_CNT) begin
        fill_next = fill + ONE;
      end
      line_next[0] = i_data ? TAG_MARK : TAG_ZERO;
      for (int i = 1; i < D; i++) begin
        line_next[i] = line[i-1];
      end
      if (i_data) begin
        run_next    = '0;
        parity_next = ~parity;
      end else begin
        // A mode change restarts the run so a straddling run is never replaced.
        if (i_mode != prev_mode) begin
          run_inc = ONE;
        end else if (run == D_CNT) begin
          run_inc = D_CNT;
        end else begin
          run_inc = run + ONE;
        end
        if ((i_mode == MODE_HDB) && (run_inc == D_CNT)) begin
          line_next[0] = TAG_V;
          if (!parity) begin
            line_next[D-1] = TAG_B;
          end
          parity_next = 1'b0;
          run_next    = '0;
        end else begin
          run_next = run_inc;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < D; i++) begin
        line[i] <= TAG_ZERO;
      end
      fill      <= '0;
      run       <= '0;
      parity    <= 1'b0;
      prev_mode <= MODE_HDB;
    end else begin
      line      <= line_next;
      fill      <= fill_next;
      run       <= run_next;
      parity    <= parity_next;
      prev_mode <= prev_mode_next;
    end
  end

  lc_polarity u_polarity (
    .clk    (i_clk),
    .rst    (i_rst),
    .emit   (emit),
    .tag    (line[D-1]),
    .valid  (o_valid),
    .code   (o_code),
    .bpulse (o_bpulse),
    .viol   (o_viol)
  );

endmodule

// File: tb/tb_hdbn_encoder.sv
// Directed bench for hdbn_encoder: HDB3 and N_HDB=2 instances share one
// input stream; emitted symbols are collected and compared to hand tables.
module tb_hdbn_encoder;
  import line_code_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, valid, data, mode;
  logic       ov3, ob3, oviol3;
  logic [1:0] oc3;
  logic       ov2, ob2, oviol2;
  logic [1:0] oc2;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [3:0] cap[$];

  hdbn_encoder #(.N_HDB(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_mode(mode),
    .o_valid(ov3), .o_code(oc3), .o_bpulse(ob3), .o_viol(oviol3)
  );

  hdbn_encoder #(.N_HDB(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_mode(mode),
    .o_valid(ov2), .o_code(oc2), .o_bpulse(ob2), .o_viol(oviol2)
  );

  task automatic check_value(input string name, input logic [3:0] obs, input logic [3:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %b expected %b", name, obs, exp);
    end
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic apply_stimulus(input logic v, input logic d, input logic m, input int sel,
                                input logic exp_valid, input string name);
    logic       ov, ob, ovi;
    logic [1:0] oc;
    @(negedge clk);
    valid = v;
    data  = d;
    mode  = m;
    @(posedge clk);
    #1;
    if (sel == 2) begin
      ov = ov2; ob = ob2; ovi = oviol2; oc = oc2;
    end else begin
      ov = ov3; ob = ob3; ovi = oviol3; oc = oc3;
    end
    check_value({name, " o_valid"}, {3'b000, ov}, {3'b000, exp_valid});
    if (!ov) check_value({name, " idle flags"}, {2'b00, ob, ovi}, 4'b0000);
    if (ov) cap.push_back({ob, ovi, oc});
  endtask

  task automatic send_bits(input string name, input logic [31:0] bits, input int n,
                           input logic m, input bit gaps, input int sel, input int d);
    cap.delete();
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1'b1, bits[n-1-i], m, sel, (i >= d), name);
      if (gaps) apply_stimulus(1'b0, 1'b0, m, sel, 1'b0, name);
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Expected tables are written first symbol leftmost: {bpulse, viol, code}.
  task automatic check_output(input string name, input int n, input logic [63:0] codes,
                              input logic [31:0] bm, input logic [31:0] vm);
    logic [3:0] exp;
    logic [3:0] obs;
    check_value({name, " count"}, (cap.size() >= n) ? 4'd1 : 4'd0, 4'd1);
    for (int i = 0; i < n; i++) begin
      exp = {bm[n-1-i], vm[n-1-i], codes[2*(n-1-i) +: 2]};
      obs = (i < cap.size()) ? cap[i] : 4'b1111;
      check_value($sformatf("%s sym%0d", name, i), obs, exp);
    end
  endtask

  task automatic do_reset(input logic v, input logic d);
    @(negedge clk);
    rst   = 1'b1;
    valid = v;
    data  = d;
    mode  = MODE_HDB;
    @(posedge clk);
    #1;
    check_value("reset flags hdb3", {1'b0, ov3, ob3, oviol3}, 4'b0000);
    check_value("reset code hdb3", {2'b00, oc3}, 4'b0000);
    check_value("reset flags hdb2", {1'b0, ov2, ob2, oviol2}, 4'b0000);
    @(negedge clk);
    rst   = 1'b0;
    valid = 1'b0;
    data  = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    data  = 1'b0;
    mode  = MODE_HDB;
    do_reset(1'b0, 1'b0);

    $display("[TB] HDB3 odd parity");
    send_bits("hdb3 odd", 32'b10000100000000, 14, MODE_HDB, 1'b0, 3, 4);
    check_output("hdb3 odd", 10, 64'b01_00_00_00_01_10_00_00_00_10,
                 32'b0000000000, 32'b0000100001);

    $display("[TB] HDB3 even parity");
    do_reset(1'b0, 1'b0);
    send_bits("hdb3 even", 32'b000000000000, 12, MODE_HDB, 1'b0, 3, 4);
    check_output("hdb3 even", 8, 64'b01_00_00_01_10_00_00_10,
                 32'b10001000, 32'b00010001);

    $display("[TB] AMI");
    do_reset(1'b0, 1'b0);
    send_bits("ami", 32'b1101000010000, 13, MODE_AMI, 1'b0, 3, 4);
    check_output("ami", 9, 64'b01_10_00_01_00_00_00_00_10,
                 32'b000000000, 32'b000000000);

    $display("[TB] valid gaps");
    do_reset(1'b0, 1'b0);
    send_bits("gaps", 32'b10000100000000, 14, MODE_HDB, 1'b1, 3, 4);
    check_output("gaps", 10, 64'b01_00_00_00_01_10_00_00_00_10,
                 32'b0000000000, 32'b0000100001);

    $display("[TB] N_HDB=2");
    do_reset(1'b0, 1'b0);
    send_bits("hdb2", 32'b000000000, 9, MODE_HDB, 1'b0, 2, 3);
    check_output("hdb2", 6, 64'b01_00_01_10_00_10,
                 32'b100100, 32'b001001);

    $display("[TB] reset mid-run");
    do_reset(1'b0, 1'b0);
    send_bits("pre-reset", 32'b000, 3, MODE_HDB, 1'b0, 3, 4);
    do_reset(1'b1, 1'b1);
    send_bits("after reset", 32'b10000100000000, 14, MODE_HDB, 1'b0, 3, 4);
    check_output("after reset", 10, 64'b01_00_00_00_01_10_00_00_00_10,
                 32'b0000000000, 32'b0000100001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hdbn_encoder.md
# hdbn_encoder

Parametrised HDBn / AMI line encoder. It turns a gated serial NRZ bit stream into ternary line symbols. It supersedes the fixed HDB3 encoder: the zero-run length is set by a parameter, AMI/HDBn mode is chosen at run time, input is qualified by a valid strobe so gaps are tolerated, and B/V marker flags are exported for the framer and for checking. It sits between the serial data source and the line driver.

## Interface
- `N_HDB`, default 3: HDBn order; a run of `D = N_HDB+1` zeros is substituted (legal range 2..7).
- `i_clk`, in, 1: sole clock, all logic on the rising edge.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_valid`, in, 1: `i_data` is accepted on this cycle.
- `i_data`, in, 1: NRZ bit (1 = mark).
- `i_mode`, in, 1: 0 = AMI, 1 = HDBn; sampled with each accepted bit.
- `o_valid`, out, 1: `o_code` carries a new symbol this cycle.
- `o_code`, out, 2: 2'b00 = 0, 2'b01 = +1, 2'b10 = -1; 2'b11 is never driven.
- `o_bpulse`, out, 1: current symbol is a substituted B pulse.
- `o_viol`, out, 1: current symbol is a V (violation) pulse.

## Operation
- **Delay line:** D entries, each holding {tag: ZERO/MARK/B/V}. It shifts only on accepted bits (`i_valid`=1); the new bit enters at the head. The bit displaced from the tail is emitted.
- **Fill counter:**
  - Counts accepted bits, saturating at D.
  - Emission is suppressed until D bits have been accepted.
  - No flush: bits still in the line are emitted only when later bits push them out.
- **Zero-run counter:**
  - Counts consecutive ZERO tags at the head.
  - Cleared by a mark, by a substitution, and when `i_mode` differs from the mode of the previously accepted bit.
- **Parity flag:**
  - Holds the parity of the number of MARK+B tags inserted since the last V.
  - Toggled by each accepted mark and by each B substitution.
  - Cleared by each V.
- **Substitution** (HDBn mode only, when an accepted 0 makes the run reach D):
  - The head entry (newest bit) becomes V.
  - If parity is even, the oldest entry of the run also becomes B; if odd, the pattern is 0…0V.
  - After substitution, parity is even and the run counter is 0.
- **AMI mode:** no substitution; tags are only ZERO/MARK.
- **Polarity** is assigned at emission from register `last_pol` (the polarity of the last nonzero emitted symbol):
  - MARK and B take the opposite of `last_pol`.
  - V takes the same polarity as `last_pol`.
  - Every nonzero symbol updates `last_pol`.
- **Reset state:** delay line all ZERO, fill = 0, run = 0, parity even, `last_pol` = negative (so the first pulse is +1).

## Timing
- The output stage is registered.
- Bit j is presented on the outputs with `o_valid`=1 exactly one cycle after the acceptance of bit j+D. Latency in accepted bits is D, independent of mode.
- `o_valid` is 1 only in the cycle after an accepted bit that emits; otherwise it is 0.
- While `o_valid`=0, `o_code` holds its previous value and `o_bpulse`/`o_viol` are 0.
- Gaps in `i_valid` stretch latency in cycles but never alter the symbol sequence.
- Reset values: `o_valid`=0, `o_code`=2'b00, `o_bpulse`=0, `o_viol`=0.
- If `i_rst` is asserted mid-stream:
  - All state returns to the reset values in the next cycle.
  - Pending bits are discarded.
  - A bit presented with `i_valid`=1 in the reset cycle is ignored.
- If the acceptance that completes a run is also an emitting acceptance, the substitution rewrites entries still in the line. The emitted tail bit precedes the run and is unaffected.
- A mode change is applied per bit: a run straddling the change is not substituted.

## Structure
- Package `line_code_pkg`:
  - Tag enum (ZERO, MARK, B, V).
  - `o_code` constants `SYM_ZERO`, `SYM_POS`, `SYM_NEG`.
  - Mode constants `MODE_AMI`, `MODE_HDB`.
- Sub-module `lc_polarity`: output register stage. It maps tag to `o_code`, maintains `last_pol`, and drives `o_valid`/`o_bpulse`/`o_viol`.
- Top module: delay line, fill/run/parity counters, substitution logic.

## Test plan
- **HDB3, parity odd:** reset, `i_valid`=1 continuously, bits 1,0,0,0,0,1,0,0,0,0 then 4 padding zeros -> first 10 symbols +1,0,0,0,+1,-1,0,0,0,-1; `o_viol` high on symbols 5 and 10.
- **HDB3, parity even:** reset, 8 zeros + 4 padding -> first 8 symbols +1,0,0,+1,-1,0,0,-1; `o_bpulse` on symbols 1 and 5, `o_viol` on symbols 4 and 8.
- **AMI:** `i_mode`=0, bits 1,1,0,1,0,0,0,0,1 + 4 padding -> +1,-1,0,+1,0,0,0,0,-1; `o_bpulse`/`o_viol` never set.
- **Valid gaps:** repeat the first case with `i_valid` toggling 1/0 -> identical symbol sequence; `o_valid` high only in the cycle after each emitting acceptance; first `o_valid` after the 5th acceptance.
- **`N_HDB`=2:** 6 zeros from reset -> +1,0,+1,-1,0,-1 (B0V pattern).
- **Reset mid-run:** 3 zeros accepted, then `i_rst` for one cycle, then the first case -> output identical to the first case; outputs 0 the cycle after reset.
